ctrl_fsm: RTL

Parametrised next-generation SISC control unit. Sequences each instruction through fetch/decode/execute/mem/writeback and drives every datapath control strobe. Adds load/store with a memory-ready stall, two-cycle SWP, a latched HALT state and a status-register write enable. Sits between the IR/status register and the PC, register file, ALU and data memory.

---
 rtl/ctrl_pkg.sv | 31 +++
 rtl/ctrl_fsm_if.sv | 28 ++
 rtl/ctrl_br_eval.sv | 24 ++
 rtl/ctrl_fsm.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the SISC control unit: FSM states, opcodes and alu_op codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_START     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_SWP2      = 3'd6,
    S_HALT      = 3'd7
  } state_e;

  localparam logic [3:0] OPC_NOOP = 4'd0;
  localparam logic [3:0] OPC_LOD  = 4'd1;
  localparam logic [3:0] OPC_STR  = 4'd2;
  localparam logic [3:0] OPC_SWP  = 4'd3;
  localparam logic [3:0] OPC_BRA  = 4'd4;
  localparam logic [3:0] OPC_BRR  = 4'd5;
  localparam logic [3:0] OPC_BNE  = 4'd6;
  localparam logic [3:0] OPC_BNR  = 4'd7;
  localparam logic [3:0] OPC_ALU  = 4'd8;
  localparam logic [3:0] OPC_HLT  = 4'd15;

  localparam logic [1:0] ALUOP_REG     = 2'b00;
  localparam logic [1:0] ALUOP_IMM     = 2'b01;
  localparam logic [1:0] ALUOP_IDLE    = 2'b10;
  localparam logic [1:0] ALUOP_IMM_MEM = 2'b11;

endpackage

// File: rtl/ctrl_fsm_if.sv
// IR/status inputs and datapath strobes of the control unit; master = controller side.
interface ctrl_fsm_if #(
  parameter int OP_W = 4,
  parameter int CC_W = 4
);
  logic [OP_W-1:0] opcode;
  logic [CC_W-1:0] mm;
  logic [CC_W-1:0] stat;
  logic            mem_ready;

  logic            rf_we, wb_sel, rb_sel, br_sel;
  logic            pc_rst, pc_write, pc_sel, ir_load;
  logic [1:0]      alu_op;
  logic            dm_we, mm_sel, stat_en, halted;
  logic [2:0]      state;

  modport master (
    input  opcode, mm, stat, mem_ready,
    output rf_we, wb_sel, rb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load,
           alu_op, dm_we, mm_sel, stat_en, halted, state
  );

  modport slave (
    output opcode, mm, stat, mem_ready,
    input  rf_we, wb_sel, rb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load,
           alu_op, dm_we, mm_sel, stat_en, halted, state
  );
endinterface

// File: rtl/ctrl_br_eval.sv
// Branch condition evaluation: hit when any mm bit matches a set status bit.
module ctrl_br_eval
  import ctrl_pkg::*;
#(
  parameter int OP_W = 4,
  parameter int CC_W = 4
) (
  input  logic [OP_W-1:0] opcode,
  input  logic [CC_W-1:0] mm,
  input  logic [CC_W-1:0] stat,
  output logic            taken,
  output logic            is_branch,
  output logic            rel
);
  logic hit, br_pos, br_neg;

  assign hit       = |(mm & stat);
  assign br_pos    = (opcode == OP_W'(OPC_BRA)) || (opcode == OP_W'(OPC_BRR));
  assign br_neg    = (opcode == OP_W'(OPC_BNE)) || (opcode == OP_W'(OPC_BNR));
  assign is_branch = br_pos || br_neg;
  assign rel       = (opcode == OP_W'(OPC_BRR)) || (opcode == OP_W'(OPC_BNR));
  // BNE/BNR branch on the absence of a condition match
  assign taken     = (br_pos && hit) || (br_neg && !hit);
endmodule

// File: rtl/ctrl_fsm.sv
// SISC control unit: fetch/decode/execute/mem/writeback sequencer with memory stalls and HALT.
// CTRL_SWP_EN enables the two-cycle SWP writeback via SWP2; otherwise SWP runs as NOOP.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int CC_W   = 4,
  parameter int IMM_MM = 8
) (
  input  logic       clk,
  input  logic       rst,
  ctrl_fsm_if.master bus
);
  state_e state_q;

  logic is_alu, is_imm, is_lod, is_str, is_hlt, mem_op;
  logic taken, is_branch, rel;

  assign is_alu = (bus.opcode == OP_W'(OPC_ALU));
  assign is_imm = is_alu && (bus.mm == CC_W'(IMM_MM));
  assign is_lod = (bus.opcode == OP_W'(OPC_LOD));
  assign is_str = (bus.opcode == OP_W'(OPC_STR));
  assign is_hlt = (bus.opcode == OP_W'(OPC_HLT));
  assign mem_op = is_lod || is_str;

`ifdef CTRL_SWP_EN
  logic is_swp;
  assign is_swp = (bus.opcode == OP_W'(OPC_SWP));
`endif

  ctrl_br_eval #(.OP_W(OP_W), .CC_W(CC_W)) u_br_eval (
    .opcode    (bus.opcode),
    .mm        (bus.mm),
    .stat      (bus.stat),
    .taken     (taken),
    .is_branch (is_branch),
    .rel       (rel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_START;
    end else begin
      case (state_q)
        S_START:     state_q <= S_FETCH;
        S_FETCH:     if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE:    state_q <= is_hlt ? S_HALT : S_EXECUTE;
        S_EXECUTE:   state_q <= S_MEM;
        S_MEM:       if (!mem_op || bus.mem_ready) state_q <= S_WRITEBACK;
`ifdef CTRL_SWP_EN
        S_WRITEBACK: state_q <= is_swp ? S_SWP2 : S_FETCH;
        S_SWP2:      state_q <= S_FETCH;
`else
        S_WRITEBACK: state_q <= S_FETCH;
`endif
        S_HALT:      state_q <= S_HALT;
        default:     state_q <= S_START;
      endcase
    end
  end

  logic       rf_we, wb_sel, rb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load;
  logic       dm_we, mm_sel, stat_en, halted;
  logic [1:0] alu_op;

  always_comb begin
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    rb_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    ir_load  = 1'b0;
    dm_we    = 1'b0;
    mm_sel   = 1'b0;
    stat_en  = 1'b0;
    halted   = 1'b0;
    alu_op   = ALUOP_IDLE;
    case (state_q)
      S_START: pc_rst = 1'b1;
      S_FETCH: if (bus.mem_ready) begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      // Not-taken branches need no PC write: FETCH already advanced it
      S_DECODE: if (is_branch && taken) begin
        pc_write = 1'b1;
        pc_sel   = 1'b1;
        br_sel   = rel;
      end
      S_EXECUTE: alu_op = is_imm ? ALUOP_IMM : ALUOP_REG;
      S_MEM: begin
        alu_op = is_imm ? ALUOP_IMM_MEM : ALUOP_IDLE;
        mm_sel = mem_op;
        dm_we  = is_str;
      end
      S_WRITEBACK: begin
        rf_we   = is_alu || is_lod;
        stat_en = is_alu;
        wb_sel  = is_lod;
`ifdef CTRL_SWP_EN
        if (is_swp) begin
          rf_we  = 1'b1;
          rb_sel = 1'b1;
        end
`endif
      end
`ifdef CTRL_SWP_EN
      S_SWP2: rf_we = 1'b1;
`endif
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.rf_we    = rf_we;
  assign bus.wb_sel   = wb_sel;
  assign bus.rb_sel   = rb_sel;
  assign bus.br_sel   = br_sel;
  assign bus.pc_rst   = pc_rst;
  assign bus.pc_write = pc_write;
  assign bus.pc_sel   = pc_sel;
  assign bus.ir_load  = ir_load;
  assign bus.alu_op   = alu_op;
  assign bus.dm_we    = dm_we;
  assign bus.mm_sel   = mm_sel;
  assign bus.stat_en  = stat_en;
  assign bus.halted   = halted;
  assign bus.state    = state_q;
endmodule
